// File: rtl/ifetch_mem_responder_if.sv
// Fetch request/response and byte-wide RAM bus bundle for ifetch_mem_responder.
// slave = responder side, master = requester / memory / environment side.
interface ifetch_mem_responder_if #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
);
  logic                   rdy;
  logic                   clear_flag;
  logic                   req_valid;
  logic [ADDR_W-1:0]      req_addr;
  logic [3:0]             req_len;
  logic                   data_busy;
  logic [7:0]             mem_din;
  logic                   snoop_valid;
  logic [ADDR_W-1:0]      snoop_addr;
  logic                   ins_ok;
  logic [8*MAX_BYTES-1:0] ins_ans;
  logic                   busy;
  logic [ADDR_W-1:0]      mem_a;
  logic                   mem_wr;

  modport slave (
    input  rdy, clear_flag, req_valid, req_addr, req_len, data_busy, mem_din,
           snoop_valid, snoop_addr,
    output ins_ok, ins_ans, busy, mem_a, mem_wr
  );

  modport master (
    output rdy, clear_flag, req_valid, req_addr, req_len, data_busy, mem_din,
           snoop_valid, snoop_addr,
    input  ins_ok, ins_ans, busy, mem_a, mem_wr
  );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch responder: reads up to MAX_BYTES bytes over the 8-bit RAM bus
// and returns a little-endian word. Optional one-word buffer: IFETCH_WORD_BUFFER_EN.
module ifetch_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ifetch_mem_responder_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d, len_q, len_d, req_len_sat;
  logic [ADDR_W-1:0]            mem_a_q, mem_a_d;
  logic                         busy_q, busy_d, ins_ok_q, ins_ok_d;
  logic [MAX_BYTES-1:0][7:0]    ans_q, ans_d;
  logic                         accept;
`ifdef IFETCH_WORD_BUFFER_EN
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic                         buf_valid_q, buf_valid_d, snoop_hit, buf_hit;
  logic [ADDR_W-3:0]            buf_addr_q, buf_addr_d;
  logic [MAX_BYTES-1:0][7:0]    buf_word_q, buf_word_d;
`endif
  logic                         unused_snoop;

  assign unused_snoop = bus.snoop_valid ^ (^bus.snoop_addr);
  assign accept       = bus.req_valid && !bus.data_busy && !bus.clear_flag;

  // A zero length still fetches one byte; oversize lengths clamp to MAX_BYTES.
  always_comb begin
    if (bus.req_len == 4'd0)                req_len_sat = CNT_W'(1);
    else if (32'(bus.req_len) > MAX_BYTES)  req_len_sat = CNT_W'(MAX_BYTES);
    else                                    req_len_sat = CNT_W'(bus.req_len);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    mem_a_d  = mem_a_q;
    busy_d   = busy_q;
    ins_ok_d = 1'b0;
    ans_d    = ans_q;
`ifdef IFETCH_WORD_BUFFER_EN
    addr_d      = addr_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_word_d  = buf_word_q;
    snoop_hit   = bus.snoop_valid && (bus.snoop_addr[ADDR_W-1:2] == buf_addr_q);
    buf_hit     = buf_valid_q && !snoop_hit && (req_len_sat == CNT_W'(MAX_BYTES)) &&
                  (bus.req_addr[1:0] == 2'b00) && (bus.req_addr[ADDR_W-1:2] == buf_addr_q);
`endif
    unique case (state_q)
      S_IDLE: if (accept) begin
        ans_d = '0;
        len_d = req_len_sat;
        cnt_d = '0;
`ifdef IFETCH_WORD_BUFFER_EN
        addr_d = bus.req_addr;
        if (buf_hit) begin
          ans_d    = buf_word_q;
          ins_ok_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          mem_a_d = bus.req_addr;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
`else
        mem_a_d = bus.req_addr;
        busy_d  = 1'b1;
        state_d = S_READ;
`endif
      end
      S_READ: if (bus.clear_flag) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        mem_a_d = '0;
      end else begin
        // mem_din lags mem_a by one cycle, so cnt=k captures byte k-1.
        if (cnt_q != '0) ans_d[IDX_W'(cnt_q - CNT_W'(1))] = bus.mem_din;
        if (cnt_q == len_q) begin
          state_d  = S_DONE;
          ins_ok_d = 1'b1;
`ifdef IFETCH_WORD_BUFFER_EN
          if (len_q == CNT_W'(MAX_BYTES) && addr_q[1:0] == 2'b00) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = addr_q[ADDR_W-1:2];
            buf_word_d  = ans_d;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) < len_q) mem_a_d = mem_a_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        mem_a_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef IFETCH_WORD_BUFFER_EN
    if (bus.snoop_valid && bus.snoop_addr[ADDR_W-1:2] == buf_addr_d) buf_valid_d = 1'b0;
    if (bus.clear_flag) buf_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      mem_a_q  <= '0;
      busy_q   <= 1'b0;
      ins_ok_q <= 1'b0;
      ans_q    <= '0;
`ifdef IFETCH_WORD_BUFFER_EN
      addr_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_word_q  <= '0;
`endif
    end else if (bus.rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mem_a_q  <= mem_a_d;
      busy_q   <= busy_d;
      ins_ok_q <= ins_ok_d;
      ans_q    <= ans_d;
`ifdef IFETCH_WORD_BUFFER_EN
      addr_q      <= addr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_word_q  <= buf_word_d;
`endif
    end
  end

  assign bus.ins_ok  = ins_ok_q;
  assign bus.ins_ans = ans_q;
  assign bus.busy    = busy_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_wr  = 1'b0;
endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed + randomized bench for ifetch_mem_responder against a transaction-level model.
module tb_ifetch_mem_responder;
`ifdef IFETCH_WORD_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk, rst;
  int   errors = 0, checks = 0;

  // buffer model: last fully fetched aligned word, until invalidated
  bit          mv = 1'b0;
  logic [29:0] maddr = '0;

  ifetch_mem_responder_if #(.ADDR_W(32), .MAX_BYTES(4)) m ();
  ifetch_mem_responder #(.ADDR_W(32), .MAX_BYTES(4)) dut (.clk(clk), .rst(rst), .bus(m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      32'h200: return 8'hAA;
      32'h201: return 8'hBB;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // RAM answers one cycle after the address; it freezes with the rest of the chip on rdy=0
  always @(posedge clk) if (m.rdy) m.mem_din <= ram_rd(m.mem_a);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request in the current cycle and follows it to completion.
  task automatic fetch(input logic [31:0] addr, input int rlen, input int frz_at,
                       input int frz_n, input bit snp);
    int          len, lat, n, e, okc, okat, bad_a, bad_b;
    bit          hit, eb;
    logic [31:0] exp, ea, ans_at_ok, saddr;
    len   = (rlen == 0) ? 1 : ((rlen > 4) ? 4 : rlen);
    saddr = addr + 32'd2;
    hit   = BUF_EN && mv && len == 4 && addr[1:0] == 2'b00 && addr[31:2] == maddr && !snp;
    exp   = '0;
    for (int k = 0; k < len; k++) exp |= 32'(ram_rd(addr + 32'(k))) << (8 * k);
    n   = hit ? 0 : frz_n;
    lat = hit ? 1 : len + 2 + n;
    m.req_valid = 1'b1; m.req_addr = addr; m.req_len = 4'(rlen);
    m.snoop_valid = snp; m.snoop_addr = saddr;
    step();
    m.req_valid = 1'b0; m.snoop_valid = 1'b0;
    okc = 0; okat = -1; bad_a = 0; bad_b = 0; ans_at_ok = '0;
    for (int c = 1; c <= lat + 2; c++) begin
      e = (n == 0 || c <= frz_at) ? c : ((c <= frz_at + n) ? frz_at : c - n);
      if (!hit && e <= len + 2) begin
        eb = 1'b1;
        ea = addr + 32'(((e < len) ? e : len) - 1);
      end else begin
        eb = 1'b0;
        ea = '0;
      end
      if (m.busy !== eb)  bad_b++;
      if (m.mem_a !== ea) bad_a++;
      if (m.ins_ok === 1'b1) begin
        okc++;
        if (okat < 0) begin okat = c; ans_at_ok = m.ins_ans; end
      end
      m.rdy = !(n > 0 && c >= frz_at && c < frz_at + n);
      if (c < lat + 2) step();
    end
    m.rdy = 1'b1;
    chk("ok_count", okc, 1);
    chk("ok_latency", okat, lat);
    chk("ins_ans", ans_at_ok, exp);
    chk("ans_hold", m.ins_ans, exp);
    chk("mem_a_trace", bad_a, 0);
    chk("busy_trace", bad_b, 0);
    if (snp && mv && saddr[31:2] == maddr) mv = 1'b0;
    if (!hit && len == 4 && addr[1:0] == 2'b00) begin mv = 1'b1; maddr = addr[31:2]; end
  endtask

  initial begin
    int bad, rl, ls, fa, fn;
    logic [31:0] ra;
    rst = 1'b1;
    m.rdy = 1'b1; m.clear_flag = 1'b0; m.req_valid = 1'b0; m.req_addr = '0; m.req_len = '0;
    m.data_busy = 1'b0; m.snoop_valid = 1'b0; m.snoop_addr = '0;
    step(); step();
    chk("rst_ins_ok", m.ins_ok, 0);
    chk("rst_ins_ans", m.ins_ans, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_mem_a", m.mem_a, 0);
    chk("rst_mem_wr", m.mem_wr, 0);
    rst = 1'b0;
    step();

    fetch(32'h100, 4, 0, 0, 0);
    fetch(32'h200, 2, 0, 0, 0);

    // dropped requests: data side owns the bus, then a flush in the same cycle
    for (int d = 0; d < 2; d++) begin
      m.req_valid = 1'b1; m.req_addr = 32'h300; m.req_len = 4'd4;
      if (d == 0) m.data_busy = 1'b1; else m.clear_flag = 1'b1;
      step();
      m.req_valid = 1'b0; m.data_busy = 1'b0; m.clear_flag = 1'b0;
      if (d == 1) mv = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        if (m.busy !== 1'b0 || m.ins_ok !== 1'b0) bad++;
        step();
      end
      chk(d == 0 ? "drop_data_busy" : "drop_clear", bad, 0);
    end
    fetch(32'h300, 4, 0, 0, 0);

    // flush at T+3 of a 4-byte fetch
    m.req_valid = 1'b1; m.req_addr = 32'h400; m.req_len = 4'd4;
    step(); m.req_valid = 1'b0;
    step(); step();
    m.clear_flag = 1'b1;
    step(); m.clear_flag = 1'b0; mv = 1'b0;
    chk("clr_busy", m.busy, 0);
    chk("clr_mem_a", m.mem_a, 0);
    chk("clr_ins_ok_t4", m.ins_ok, 0);
    step();
    chk("clr_ins_ok_t5", m.ins_ok, 0);
    fetch(32'h404, 4, 0, 0, 0);

    fetch(32'h500, 4, 2, 3, 0);
    fetch(32'hFFFF_FFFE, 4, 0, 0, 0);
    fetch(32'h600, 0, 0, 0, 0);
    fetch(32'h701, 9, 0, 0, 0);
    fetch(32'h803, 3, 1, 2, 0);

    // reset while reading
    m.req_valid = 1'b1; m.req_addr = 32'h900; m.req_len = 4'd4;
    step(); m.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step(); rst = 1'b0; mv = 1'b0;
    chk("rst_mid_busy", m.busy, 0);
    chk("rst_mid_mem_a", m.mem_a, 0);
    chk("rst_mid_ans", m.ins_ans, 0);
    chk("rst_mid_ok", m.ins_ok, 0);

    // word buffer sequence (all bus reads when the buffer is absent)
    fetch(32'h100, 4, 0, 0, 0);
    fetch(32'h100, 4, 0, 0, 0);
    m.snoop_valid = 1'b1; m.snoop_addr = 32'h102;
    step(); m.snoop_valid = 1'b0;
    if (mv && maddr == 30'(32'h102 >> 2)) mv = 1'b0;
    fetch(32'h100, 4, 0, 0, 0);
    fetch(32'h100, 4, 0, 0, 0);
    fetch(32'h100, 4, 0, 0, 1);
    fetch(32'h100, 4, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra = 32'h1000 + 32'($urandom_range(0, 3) << 2);
      rl = int'($urandom_range(0, 6));
      ls = (rl == 0) ? 1 : ((rl > 4) ? 4 : rl);
      fa = 0; fn = 0;
      if ($urandom_range(0, 3) == 0) begin
        fa = int'($urandom_range(1, ls));
        fn = int'($urandom_range(1, 3));
      end
      fetch(ra, rl, fa, fn, $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
